// File: rtl/burst_pkg.sv
// Shared definitions for the burst command transmitter: state encoding,
// default field widths, mode encoding and the parity-slot count.
// Optional build macro: BURST_PARITY_EN (adds one even-parity bit after each field).
package burst_pkg;

    localparam int LEN_W_DEF  = 4;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_BURST  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_LEN  = 3'd1,
        SEND_ADDR = 3'd2,
        WAIT_DATA = 3'd3,
        SEND_DATA = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Number of extra sdo cycles appended to every field.
`ifdef BURST_PARITY_EN
    localparam int PAR_CYC = 1;
`else
    localparam int PAR_CYC = 0;
`endif

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_piso.sv
// Parallel-load, MSB-first shift register for the burst frame fields.
// A field narrower than the register is left-aligned on load so its MSB
// is always at the output bit.
// Optional build macro: BURST_PARITY_EN (latches even parity of the loaded field).
module burst_piso #(
    parameter int W     = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [CNT_W-1:0] field_w,
    input  logic [W-1:0]     din,
    output logic             msb,
    output logic             parity
);

    logic [W-1:0]     sh;
    logic [CNT_W-1:0] amt;

    assign amt = CNT_W'(W) - field_w;
    assign msb = sh[W-1];

    // Load a left-aligned field, or move the next bit up to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sh <= '0;
        else if (load)
            sh <= din << amt;
        else if (shift)
            sh <= sh << 1;
    end

`ifdef BURST_PARITY_EN
    logic par;

    // Capture even parity of the field as it is loaded (din is zero above the field).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par <= 1'b0;
        else if (load)
            par <= ^din;
    end

    assign parity = par;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: rtl/burst_cmd_tx.sv
// Host-side burst frame transmitter: serialises [burst length], start address
// and one data word per beat, MSB first, one bit per clk on sdo/sdo_valid.
// Optional build macro: BURST_PARITY_EN (one even-parity bit after each field).
module burst_cmd_tx
    import burst_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_sel,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              data_req,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt
);

    localparam int PW    = max2(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(max2(max2(LEN_W, ADDR_W), DATA_W)) + 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cur_w;
    logic [CNT_W-1:0]  load_w;
    logic [PW-1:0]     load_val;
    logic              mode_r;
    logic [LEN_W-1:0]  len_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  beat_r;
    logic [LEN_W-1:0]  last_beat;
    logic              load, shift, latch, beat_inc;
    logic              sending, last_bit;
    logic              msb, parity;

    // Field width of the state being transmitted; the parity slot sits at index cur_w.
    always_comb begin
        cur_w = CNT_W'(DATA_W);
        case (state)
            SEND_LEN:  cur_w = CNT_W'(LEN_W);
            SEND_ADDR: cur_w = CNT_W'(ADDR_W);
            default:   cur_w = CNT_W'(DATA_W);
        endcase
    end

    assign sending   = (state == SEND_LEN) || (state == SEND_ADDR) || (state == SEND_DATA);
    assign last_bit  = (bit_cnt == cur_w + CNT_W'(PAR_CYC) - CNT_W'(1));
    assign last_beat = (mode_r == MODE_BURST) ? len_r : '0;

    assign sdo_valid = sending;
    assign sdo       = sending & ((bit_cnt == cur_w) ? parity : msb);
    assign busy      = (state != IDLE);
    assign beat_cnt  = beat_r;

    // Next-state decode plus shift-register and handshake controls.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        load_val  = '0;
        load_w    = cur_w;
        latch     = 1'b0;
        beat_inc  = 1'b0;
        data_req  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    load  = 1'b1;
                    if (mode_sel == MODE_BURST) begin
                        state_nxt = SEND_LEN;
                        load_val  = PW'(burst_len);
                        load_w    = CNT_W'(LEN_W);
                    end else begin
                        state_nxt = SEND_ADDR;
                        load_val  = PW'(start_addr);
                        load_w    = CNT_W'(ADDR_W);
                    end
                end
            end
            SEND_LEN: begin
                if (last_bit) begin
                    state_nxt = SEND_ADDR;
                    load      = 1'b1;
                    load_val  = PW'(addr_r);
                    load_w    = CNT_W'(ADDR_W);
                end else begin
                    shift = 1'b1;
                end
            end
            SEND_ADDR: begin
                if (last_bit)
                    state_nxt = WAIT_DATA;
                else
                    shift = 1'b1;
            end
            WAIT_DATA: begin
                data_req = 1'b1;
                if (data_valid) begin
                    state_nxt = SEND_DATA;
                    load      = 1'b1;
                    load_val  = PW'(data_in);
                    load_w    = CNT_W'(DATA_W);
                end
            end
            SEND_DATA: begin
                if (last_bit) begin
                    if (beat_r == last_beat) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT_DATA;
                        beat_inc  = 1'b1;
                    end
                end else begin
                    shift = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Bit position within the current field, restarting at every field boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bit_cnt <= '0;
        else if (sending && !last_bit)
            bit_cnt <= bit_cnt + CNT_W'(1);
        else
            bit_cnt <= '0;
    end

    // Frame parameters are captured once at start and held for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_SINGLE;
            len_r  <= '0;
            addr_r <= '0;
        end else if (latch) begin
            mode_r <= mode_sel;
            len_r  <= burst_len;
            addr_r <= start_addr;
        end
    end

    // Beat index: compared before incrementing, so the last beat never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_r <= '0;
        else if (latch || state == DONE)
            beat_r <= '0;
        else if (beat_inc)
            beat_r <= beat_r + LEN_W'(1);
    end

    burst_piso #(
        .W     (PW),
        .CNT_W (CNT_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .field_w (load_w),
        .din     (load_val),
        .msb     (msb),
        .parity  (parity)
    );

endmodule
